// File: rtl/mem_access_stage_if.sv
// Data cache request/response bus used by the MEM stage.
// The stage drives requests (master); the cache answers with a one-cycle
// completion pulse carrying the aligned doubleword (slave).
interface mem_access_stage_if #(
   parameter int BUS_DATA_WIDTH = 64
);
   localparam int STRB_W = BUS_DATA_WIDTH / 8;

   logic                      dc_req;
   logic                      dc_we;
   logic [BUS_DATA_WIDTH-1:0] dc_addr;
   logic [BUS_DATA_WIDTH-1:0] dc_wdata;
   logic [STRB_W-1:0]         dc_wstrb;
   logic                      dc_resp;
   logic [BUS_DATA_WIDTH-1:0] dc_rdata;

   modport master (
      output dc_req,
      output dc_we,
      output dc_addr,
      output dc_wdata,
      output dc_wstrb,
      input  dc_resp,
      input  dc_rdata
   );

   modport slave (
      input  dc_req,
      input  dc_we,
      input  dc_addr,
      input  dc_wdata,
      input  dc_wstrb,
      output dc_resp,
      output dc_rdata
   );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: performs loads/stores through the dcache bus, extracts
// and extends load data, and registers every writeback field. The front of
// the pipeline is held while a dcache transaction is outstanding.
module mem_access_stage #(
   parameter int BUS_DATA_WIDTH = 64
) (
   input  logic                      clk,
   input  logic                      reset,

   input  logic                      in_valid,
   input  logic                      in_mem_read,
   input  logic                      in_mem_write,
   input  logic [2:0]                in_funct3,
   input  logic [BUS_DATA_WIDTH-1:0] in_address,
   input  logic [BUS_DATA_WIDTH-1:0] in_store_data,
   input  logic [BUS_DATA_WIDTH-1:0] in_result,
   input  logic [4:0]                in_dest_register,
   input  logic                      in_reg_write,
   input  logic                      in_mem_or_reg,
   input  logic                      in_jump,
   input  logic [BUS_DATA_WIDTH-1:0] in_pc,
   input  logic                      in_ecall,
   input  logic                      in_flush,

   mem_access_stage_if.master        dc,

   output logic                      out_stall,
   output logic                      out_valid,
   output logic [BUS_DATA_WIDTH-1:0] out_read_data,
   output logic [BUS_DATA_WIDTH-1:0] out_result,
   output logic [BUS_DATA_WIDTH-1:0] out_pc,
   output logic [4:0]                out_dest_register,
   output logic                      out_reg_write,
   output logic                      out_mem_or_reg,
   output logic                      out_jump,
   output logic                      out_ecall,
   output logic                      out_do_pending_write,
   output logic [BUS_DATA_WIDTH-1:0] out_address_pending_write,
   output logic [BUS_DATA_WIDTH-1:0] out_data_pending_write,
   output logic [3:0]                out_size_pending_write,
   output logic                      out_misaligned
);

   localparam int STRB_W = BUS_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                    r_state;

   // Instruction captured when a dcache access is launched
   logic [2:0]                r_funct3;
   logic [1:0]                r_size;
   logic                      r_is_store;
   logic [BUS_DATA_WIDTH-1:0] r_address;
   logic [BUS_DATA_WIDTH-1:0] r_store_data;
   logic [BUS_DATA_WIDTH-1:0] r_result;
   logic [BUS_DATA_WIDTH-1:0] r_pc;
   logic [4:0]                r_dest_register;
   logic                      r_reg_write;
   logic                      r_mem_or_reg;
   logic                      r_jump;
   logic                      r_ecall;
   logic                      r_flushed;

   logic                      w_is_mem;
   logic [1:0]                w_size;
   logic                      w_misaligned;
   logic                      w_accept;
   logic                      w_squash;
   logic [STRB_W-1:0]         w_size_mask;
   logic [5:0]                w_in_shift;
   logic [5:0]                w_r_shift;
   logic [BUS_DATA_WIDTH-1:0] w_lane;
   logic [BUS_DATA_WIDTH-1:0] w_load_data;

   assign w_is_mem   = in_mem_read | in_mem_write;
   assign w_in_shift = {in_address[2:0], 3'b000};
   assign w_r_shift  = {r_address[2:0], 3'b000};
   assign w_lane     = dc.dc_rdata >> w_r_shift;

   // A store with funct3 1xx has no unsigned form, so it is widened to a doubleword
   always_comb begin
      w_size = in_funct3[1:0];
      if (in_mem_write && in_funct3[2]) begin
         w_size = 2'b11;
      end
   end

   // Natural-alignment check for the incoming access and its byte mask
   always_comb begin
      w_misaligned = 1'b0;
      w_size_mask  = STRB_W'(8'h01);
      case (w_size)
         2'b00: begin
            w_misaligned = 1'b0;
            w_size_mask  = STRB_W'(8'h01);
         end
         2'b01: begin
            w_misaligned = in_address[0];
            w_size_mask  = STRB_W'(8'h03);
         end
         2'b10: begin
            w_misaligned = (in_address[1:0] != 2'b00);
            w_size_mask  = STRB_W'(8'h0F);
         end
         default: begin
            w_misaligned = (in_address[2:0] != 3'b000);
            w_size_mask  = STRB_W'(8'hFF);
         end
      endcase
   end

   // DONE behaves like IDLE for acceptance; only ACCESS blocks a new instruction
   assign w_accept  = (r_state != ACCESS) & in_valid & w_is_mem & ~in_flush & ~w_misaligned;
   assign out_stall = w_accept | (r_state == ACCESS);

   // A flush seen at any point during the access, including the response cycle, kills the result
   assign w_squash = r_flushed | in_flush;

   // Truncate the selected lane to the access size, then sign- or zero-extend
   always_comb begin
      w_load_data = w_lane;
      case (r_funct3)
         3'b000:  w_load_data = {{(BUS_DATA_WIDTH-8){w_lane[7]}},   w_lane[7:0]};
         3'b001:  w_load_data = {{(BUS_DATA_WIDTH-16){w_lane[15]}}, w_lane[15:0]};
         3'b010:  w_load_data = {{(BUS_DATA_WIDTH-32){w_lane[31]}}, w_lane[31:0]};
         3'b100:  w_load_data = {{(BUS_DATA_WIDTH-8){1'b0}},        w_lane[7:0]};
         3'b101:  w_load_data = {{(BUS_DATA_WIDTH-16){1'b0}},       w_lane[15:0]};
         3'b110:  w_load_data = {{(BUS_DATA_WIDTH-32){1'b0}},       w_lane[31:0]};
         default: w_load_data = w_lane;
      endcase
   end

   // Stage FSM: launches dcache accesses, waits for the response and registers all writeback fields
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state                   <= IDLE;
         r_funct3                  <= 3'b000;
         r_size                    <= 2'b00;
         r_is_store                <= 1'b0;
         r_address                 <= '0;
         r_store_data              <= '0;
         r_result                  <= '0;
         r_pc                      <= '0;
         r_dest_register           <= 5'd0;
         r_reg_write               <= 1'b0;
         r_mem_or_reg              <= 1'b0;
         r_jump                    <= 1'b0;
         r_ecall                   <= 1'b0;
         r_flushed                 <= 1'b0;
         dc.dc_req                 <= 1'b0;
         dc.dc_we                  <= 1'b0;
         dc.dc_addr                <= '0;
         dc.dc_wdata               <= '0;
         dc.dc_wstrb               <= '0;
         out_valid                 <= 1'b0;
         out_read_data             <= '0;
         out_result                <= '0;
         out_pc                    <= '0;
         out_dest_register         <= 5'd0;
         out_reg_write             <= 1'b0;
         out_mem_or_reg            <= 1'b0;
         out_jump                  <= 1'b0;
         out_ecall                 <= 1'b0;
         out_do_pending_write      <= 1'b0;
         out_address_pending_write <= '0;
         out_data_pending_write    <= '0;
         out_size_pending_write    <= 4'b0000;
         out_misaligned            <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               r_state              <= IDLE;
               dc.dc_req            <= 1'b0;
               out_valid            <= 1'b0;
               out_reg_write        <= 1'b0;
               out_jump             <= 1'b0;
               out_ecall            <= 1'b0;
               out_do_pending_write <= 1'b0;
               out_misaligned       <= 1'b0;
               if (in_valid && !in_flush) begin
                  if (!w_is_mem || w_misaligned) begin
                     out_valid         <= 1'b1;
                     out_read_data     <= '0;
                     out_result        <= in_result;
                     out_pc            <= in_pc;
                     out_dest_register <= in_dest_register;
                     out_reg_write     <= in_reg_write & ~w_is_mem;
                     out_mem_or_reg    <= in_mem_or_reg;
                     out_jump          <= in_jump;
                     out_ecall         <= in_ecall;
                     out_misaligned    <= w_is_mem;
                  end else begin
                     r_state         <= ACCESS;
                     r_funct3        <= in_funct3;
                     r_size          <= w_size;
                     r_is_store      <= in_mem_write;
                     r_address       <= in_address;
                     r_store_data    <= in_store_data;
                     r_result        <= in_result;
                     r_pc            <= in_pc;
                     r_dest_register <= in_dest_register;
                     r_reg_write     <= in_reg_write;
                     r_mem_or_reg    <= in_mem_or_reg;
                     r_jump          <= in_jump;
                     r_ecall         <= in_ecall;
                     r_flushed       <= 1'b0;
                     dc.dc_req       <= 1'b1;
                     dc.dc_we        <= in_mem_write;
                     dc.dc_addr      <= {in_address[BUS_DATA_WIDTH-1:3], 3'b000};
                     dc.dc_wdata     <= in_mem_write ? (in_store_data << w_in_shift) : '0;
                     dc.dc_wstrb     <= in_mem_write ? (w_size_mask << in_address[2:0]) : '0;
                  end
               end
            end
            ACCESS: begin
               if (in_flush) begin
                  r_flushed <= 1'b1;
               end
               if (dc.dc_resp) begin
                  r_state                   <= DONE;
                  dc.dc_req                 <= 1'b0;
                  out_valid                 <= ~w_squash;
                  out_read_data             <= r_is_store ? '0 : w_load_data;
                  out_result                <= r_result;
                  out_pc                    <= r_pc;
                  out_dest_register         <= r_dest_register;
                  out_reg_write             <= r_reg_write & ~w_squash;
                  out_mem_or_reg            <= r_mem_or_reg;
                  out_jump                  <= r_jump & ~w_squash;
                  out_ecall                 <= r_ecall & ~w_squash;
                  out_do_pending_write      <= r_is_store & ~w_squash;
                  out_address_pending_write <= r_address;
                  out_data_pending_write    <= r_store_data;
                  out_size_pending_write    <= 4'b0001 << r_size;
                  out_misaligned            <= 1'b0;
               end
            end
            default: begin
               r_state   <= IDLE;
               dc.dc_req <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: the bench plays the dcache by hand,
// choosing when the response pulse arrives, and compares every output against
// hand-computed values.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_mem_read, in_mem_write;
   logic [2:0]  in_funct3;
   logic [63:0] in_address, in_store_data, in_result, in_pc;
   logic [4:0]  in_dest_register;
   logic        in_reg_write, in_mem_or_reg, in_jump, in_ecall, in_flush;
   logic        out_stall, out_valid;
   logic [63:0] out_read_data, out_result, out_pc;
   logic [4:0]  out_dest_register;
   logic        out_reg_write, out_mem_or_reg, out_jump, out_ecall;
   logic        out_do_pending_write;
   logic [63:0] out_address_pending_write, out_data_pending_write;
   logic [3:0]  out_size_pending_write;
   logic        out_misaligned;

   int checkCount = 0;
   int errorCount = 0;
   int stallCycles;

   mem_access_stage_if #(.BUS_DATA_WIDTH(64)) dcBus ();

   mem_access_stage #(.BUS_DATA_WIDTH(64)) dut (
      .clk                       (clk),
      .reset                     (reset),
      .in_valid                  (in_valid),
      .in_mem_read               (in_mem_read),
      .in_mem_write              (in_mem_write),
      .in_funct3                 (in_funct3),
      .in_address                (in_address),
      .in_store_data             (in_store_data),
      .in_result                 (in_result),
      .in_dest_register          (in_dest_register),
      .in_reg_write              (in_reg_write),
      .in_mem_or_reg             (in_mem_or_reg),
      .in_jump                   (in_jump),
      .in_pc                     (in_pc),
      .in_ecall                  (in_ecall),
      .in_flush                  (in_flush),
      .dc                        (dcBus.master),
      .out_stall                 (out_stall),
      .out_valid                 (out_valid),
      .out_read_data             (out_read_data),
      .out_result                (out_result),
      .out_pc                    (out_pc),
      .out_dest_register         (out_dest_register),
      .out_reg_write             (out_reg_write),
      .out_mem_or_reg            (out_mem_or_reg),
      .out_jump                  (out_jump),
      .out_ecall                 (out_ecall),
      .out_do_pending_write      (out_do_pending_write),
      .out_address_pending_write (out_address_pending_write),
      .out_data_pending_write    (out_data_pending_write),
      .out_size_pending_write    (out_size_pending_write),
      .out_misaligned            (out_misaligned)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Hard stop in case the stimulus ever stops advancing
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      in_valid         = 1'b0;
      in_mem_read      = 1'b0;
      in_mem_write     = 1'b0;
      in_funct3        = 3'b000;
      in_address       = 64'h0;
      in_store_data    = 64'h0;
      in_result        = 64'h0;
      in_dest_register = 5'd0;
      in_reg_write     = 1'b0;
      in_mem_or_reg    = 1'b0;
      in_jump          = 1'b0;
      in_pc            = 64'h0;
      in_ecall         = 1'b0;
      in_flush         = 1'b0;
   endtask

   task automatic applyStimulus(input logic isRead, input logic isWrite, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] sdata,
                                input logic [63:0] result, input logic [4:0] rd,
                                input logic regWrite, input logic memOrReg, input logic jump,
                                input logic ecall, input logic [63:0] pc);
      in_valid         = 1'b1;
      in_mem_read      = isRead;
      in_mem_write     = isWrite;
      in_funct3        = f3;
      in_address       = addr;
      in_store_data    = sdata;
      in_result        = result;
      in_dest_register = rd;
      in_reg_write     = regWrite;
      in_mem_or_reg    = memOrReg;
      in_jump          = jump;
      in_ecall         = ecall;
      in_pc            = pc;
      in_flush         = 1'b0;
   endtask

   // Called in the accepting cycle; answers after nCycles of dc_req, optionally flushing on one of them
   task automatic serviceAccess(input int nCycles, input int flushCycle, input logic [63:0] rdata,
                                input logic expWe, input logic [63:0] expAddr,
                                input logic [63:0] expWdata, input logic [7:0] expStrb,
                                output int stalls);
      #1;
      stalls = out_stall ? 1 : 0;
      stepCycle();
      clearInputs();
      for (int i = 1; i <= nCycles; i++) begin
         in_flush = (i == flushCycle);
         if (i == nCycles) begin
            dcBus.dc_resp  = 1'b1;
            dcBus.dc_rdata = rdata;
         end
         #1;
         checkOutput("dcReqHeld", {63'h0, dcBus.dc_req}, 64'h1);
         if (i == 1) begin
            checkOutput("dcWe",         {63'h0, dcBus.dc_we}, {63'h0, expWe});
            checkOutput("dcAddr",       dcBus.dc_addr, expAddr);
            checkOutput("dcWdata",      dcBus.dc_wdata, expWdata);
            checkOutput("dcWstrb",      {56'h0, dcBus.dc_wstrb}, {56'h0, expStrb});
            checkOutput("validInAccess", {63'h0, out_valid}, 64'h0);
         end
         if (out_stall) stalls++;
         stepCycle();
         dcBus.dc_resp  = 1'b0;
         dcBus.dc_rdata = 64'h0;
         in_flush       = 1'b0;
      end
      #1;
   endtask

   initial begin
      reset          = 1'b1;
      clearInputs();
      dcBus.dc_resp  = 1'b0;
      dcBus.dc_rdata = 64'h0;
      stepCycle();
      stepCycle();
      checkOutput("rstValid",    {63'h0, out_valid}, 64'h0);
      checkOutput("rstDcReq",    {63'h0, dcBus.dc_req}, 64'h0);
      checkOutput("rstStall",    {63'h0, out_stall}, 64'h0);
      checkOutput("rstResult",   out_result, 64'h0);
      checkOutput("rstRegWrite", {63'h0, out_reg_write}, 64'h0);
      reset = 1'b0;
      stepCycle();

      $display("[TB] ALU pass-through");
      applyStimulus(1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 64'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 64'h100);
      #1;
      checkOutput("aluStall", {63'h0, out_stall}, 64'h0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 64'h55, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 64'h200);
      checkOutput("aluValid",    {63'h0, out_valid}, 64'h1);
      checkOutput("aluResult",   out_result, 64'h1234);
      checkOutput("aluRd",       {59'h0, out_dest_register}, 64'd5);
      checkOutput("aluRegWrite", {63'h0, out_reg_write}, 64'h1);
      checkOutput("aluPc",       out_pc, 64'h100);
      checkOutput("aluReadData", out_read_data, 64'h0);
      checkOutput("aluDcReq",    {63'h0, dcBus.dc_req}, 64'h0);
      stepCycle();
      clearInputs();
      checkOutput("jmpJump",  {63'h0, out_jump}, 64'h1);
      checkOutput("jmpEcall", {63'h0, out_ecall}, 64'h1);
      checkOutput("jmpPc",    out_pc, 64'h200);
      stepCycle();
      checkOutput("bubbleValid", {63'h0, out_valid}, 64'h0);
      checkOutput("bubbleJump",  {63'h0, out_jump}, 64'h0);

      $display("[TB] LB sign-extend, response on third request cycle");
      applyStimulus(1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 64'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 64'h300);
      serviceAccess(3, 0, 64'h00000000_80000000, 1'b0, 64'h1000, 64'h0, 8'h00, stallCycles);
      checkOutput("lbStallCycles", 64'(stallCycles), 64'd4);
      checkOutput("lbValid",    {63'h0, out_valid}, 64'h1);
      checkOutput("lbReadData", out_read_data, 64'hFFFFFFFF_FFFFFF80);
      checkOutput("lbRegWrite", {63'h0, out_reg_write}, 64'h1);
      checkOutput("lbRd",       {59'h0, out_dest_register}, 64'd7);
      checkOutput("lbMemOrReg", {63'h0, out_mem_or_reg}, 64'h1);
      checkOutput("lbDcReqOff", {63'h0, dcBus.dc_req}, 64'h0);
      checkOutput("lbStallOff", {63'h0, out_stall}, 64'h0);
      stepCycle();

      $display("[TB] LHU zero-extend, single-cycle response");
      applyStimulus(1'b1, 1'b0, 3'b101, 64'h2006, 64'h0, 64'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 64'h304);
      serviceAccess(1, 0, 64'hBEEF0000_00000000, 1'b0, 64'h2000, 64'h0, 8'h00, stallCycles);
      checkOutput("lhuStallCycles", 64'(stallCycles), 64'd2);
      checkOutput("lhuReadData", out_read_data, 64'h00000000_0000BEEF);
      checkOutput("lhuValid",    {63'h0, out_valid}, 64'h1);
      stepCycle();

      $display("[TB] SW with pending write, then LW accepted in DONE");
      applyStimulus(1'b0, 1'b1, 3'b010, 64'h3004, 64'hDEADBEEF, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h308);
      serviceAccess(2, 0, 64'h0, 1'b1, 64'h3000, 64'hDEADBEEF_00000000, 8'hF0, stallCycles);
      checkOutput("swStallCycles", 64'(stallCycles), 64'd3);
      checkOutput("swValid",   {63'h0, out_valid}, 64'h1);
      checkOutput("swPending", {63'h0, out_do_pending_write}, 64'h1);
      checkOutput("swPendAddr", out_address_pending_write, 64'h3004);
      checkOutput("swPendData", out_data_pending_write, 64'hDEADBEEF);
      checkOutput("swPendSize", {60'h0, out_size_pending_write}, 64'h4);
      checkOutput("swRegWrite", {63'h0, out_reg_write}, 64'h0);
      applyStimulus(1'b1, 1'b0, 3'b010, 64'h5004, 64'h0, 64'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 64'h30C);
      serviceAccess(1, 0, 64'h80000000_00000000, 1'b0, 64'h5000, 64'h0, 8'h00, stallCycles);
      checkOutput("lwStallCycles", 64'(stallCycles), 64'd2);
      checkOutput("lwReadData", out_read_data, 64'hFFFFFFFF_80000000);
      checkOutput("lwPending",  {63'h0, out_do_pending_write}, 64'h0);
      stepCycle();

      $display("[TB] Misaligned LW and SH");
      applyStimulus(1'b1, 1'b0, 3'b010, 64'h4002, 64'h0, 64'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 64'h310);
      #1;
      checkOutput("misStall", {63'h0, out_stall}, 64'h0);
      stepCycle();
      applyStimulus(1'b0, 1'b1, 3'b001, 64'h4001, 64'h77, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h314);
      checkOutput("misLwFlag",     {63'h0, out_misaligned}, 64'h1);
      checkOutput("misLwValid",    {63'h0, out_valid}, 64'h1);
      checkOutput("misLwRegWrite", {63'h0, out_reg_write}, 64'h0);
      checkOutput("misLwDcReq",    {63'h0, dcBus.dc_req}, 64'h0);
      stepCycle();
      clearInputs();
      checkOutput("misShFlag",    {63'h0, out_misaligned}, 64'h1);
      checkOutput("misShPending", {63'h0, out_do_pending_write}, 64'h0);
      checkOutput("misShDcReq",   {63'h0, dcBus.dc_req}, 64'h0);
      stepCycle();

      $display("[TB] Flush during access and flush with response");
      applyStimulus(1'b1, 1'b0, 3'b011, 64'h6000, 64'h0, 64'h0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 64'h318);
      serviceAccess(3, 1, 64'h11223344_55667788, 1'b0, 64'h6000, 64'h0, 8'h00, stallCycles);
      checkOutput("flushStallCycles", 64'(stallCycles), 64'd4);
      checkOutput("flushValid",    {63'h0, out_valid}, 64'h0);
      checkOutput("flushRegWrite", {63'h0, out_reg_write}, 64'h0);
      checkOutput("flushDcReq",    {63'h0, dcBus.dc_req}, 64'h0);
      stepCycle();
      applyStimulus(1'b0, 1'b1, 3'b011, 64'h6100, 64'h99, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h31C);
      serviceAccess(2, 2, 64'h0, 1'b1, 64'h6100, 64'h99, 8'hFF, stallCycles);
      checkOutput("flushRespValid",   {63'h0, out_valid}, 64'h0);
      checkOutput("flushRespPending", {63'h0, out_do_pending_write}, 64'h0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 64'hABCD, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 64'h320);
      in_flush = 1'b1;
      stepCycle();
      clearInputs();
      checkOutput("idleFlushValid",    {63'h0, out_valid}, 64'h0);
      checkOutput("idleFlushRegWrite", {63'h0, out_reg_write}, 64'h0);
      checkOutput("idleFlushJump",     {63'h0, out_jump}, 64'h0);
      dcBus.dc_resp = 1'b1;
      stepCycle();
      dcBus.dc_resp = 1'b0;
      checkOutput("strayRespValid", {63'h0, out_valid}, 64'h0);
      checkOutput("strayRespDcReq", {63'h0, dcBus.dc_req}, 64'h0);

      $display("[TB] Reset in the middle of an access");
      applyStimulus(1'b1, 1'b0, 3'b000, 64'h7000, 64'h0, 64'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 64'h324);
      stepCycle();
      clearInputs();
      #1;
      checkOutput("rstMidDcReqOn", {63'h0, dcBus.dc_req}, 64'h1);
      reset = 1'b1;
      stepCycle();
      reset = 1'b0;
      #1;
      checkOutput("rstMidDcReqOff", {63'h0, dcBus.dc_req}, 64'h0);
      checkOutput("rstMidStall",    {63'h0, out_stall}, 64'h0);
      dcBus.dc_resp = 1'b1;
      stepCycle();
      dcBus.dc_resp = 1'b0;
      checkOutput("lateRespValid", {63'h0, out_valid}, 64'h0);
      checkOutput("lateRespDcReq", {63'h0, dcBus.dc_req}, 64'h0);
      stepCycle();

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
